// File: rtl/ula.sv
// Registered integer ALU: RISC-V style opcodes, N-bit result plus Z/N/C/V flags, one cycle latency.
// Optional MUL on opcode 1001 when the macro ULA_MUL_EN is defined.
module ula #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] dataA,
   input  logic [N-1:0] dataB,
   input  logic [3:0]   ALUControl,
   output logic         out_valid,
   output logic [N-1:0] out,
   output logic         Overflow,
   output logic         Carry,
   output logic         Negative,
   output logic         Zero
);

   localparam int SW = $clog2(N);

   logic [SW-1:0]       shamt;
   logic signed [N-1:0] a_s;
   logic signed [N-1:0] b_s;
   logic [N:0]          sum_p0;
   logic [N:0]          dif_p0;
   logic [N-1:0]        res_p0;
   logic                carry_p0;
   logic                ovf_p0;

   assign shamt = dataB[SW-1:0];
   assign a_s   = dataA;
   assign b_s   = dataB;

   // Subtraction as A + ~B + 1 so bit N is the no-borrow flag
   assign sum_p0 = {1'b0, dataA} + {1'b0, dataB};
   assign dif_p0 = {1'b0, dataA} + {1'b0, ~dataB} + (N+1)'(1);

   always_comb begin
      res_p0   = '0;
      carry_p0 = 1'b0;
      ovf_p0   = 1'b0;
      case (ALUControl)
         4'b0000: begin
            res_p0   = sum_p0[N-1:0];
            carry_p0 = sum_p0[N];
            ovf_p0   = (dataA[N-1] == dataB[N-1]) && (sum_p0[N-1] != dataA[N-1]);
         end
         4'b1000: begin
            res_p0   = dif_p0[N-1:0];
            carry_p0 = dif_p0[N];
            ovf_p0   = (dataA[N-1] != dataB[N-1]) && (dif_p0[N-1] != dataA[N-1]);
         end
         4'b0001: res_p0 = dataA << shamt;
         4'b0010: res_p0 = {{(N-1){1'b0}}, (a_s < b_s)};
         4'b0011: res_p0 = {{(N-1){1'b0}}, (dataA < dataB)};
         4'b0100: res_p0 = dataA ^ dataB;
         4'b0101: res_p0 = dataA >> shamt;
         4'b0110: res_p0 = dataA | dataB;
         4'b0111: res_p0 = dataA & dataB;
         4'b1101: res_p0 = a_s >>> shamt;
`ifdef ULA_MUL_EN
         4'b1001: res_p0 = dataA * dataB;
`endif
         default: res_p0 = '0;
      endcase
   end

   // Result register: outputs only update on a valid operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         Overflow  <= 1'b0;
         Carry     <= 1'b0;
         Negative  <= 1'b0;
         Zero      <= 1'b1;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out      <= res_p0;
            Overflow <= ovf_p0;
            Carry    <= carry_p0;
            Negative <= res_p0[N-1];
            Zero     <= (res_p0 == '0);
         end
      end
   end

endmodule

// File: tb/tb_ula.sv
// Table-driven directed bench for ula (N=8), plus hold, latency and asynchronous reset sequences.
module tb_ula;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [N-1:0] dataA;
   logic [N-1:0] dataB;
   logic [3:0]   ALUControl;
   logic         out_valid;
   logic [N-1:0] out;
   logic         Overflow;
   logic         Carry;
   logic         Negative;
   logic         Zero;

   int checks = 0;
   int errors = 0;

   ula #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .dataA(dataA), .dataB(dataB), .ALUControl(ALUControl),
      .out_valid(out_valid), .out(out), .Overflow(Overflow),
      .Carry(Carry), .Negative(Negative), .Zero(Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string    name;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic z, n, c, v;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // flags packed as {Z,N,C,V}
   function automatic logic [3:0] flags();
      return {Zero, Negative, Carry, Overflow};
   endfunction

   task automatic add_vec(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input logic z, input logic n, input logic c, input logic v);
      vec_t t;
      t.name = nm; t.op = op; t.a = a; t.b = b; t.res = r;
      t.z = z; t.n = n; t.c = c; t.v = v;
      vecs.push_back(t);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      dataA      = '0;
      dataB      = '0;
      ALUControl = '0;

      //          name          op       a      b      res    z n c v
      add_vec("add_10_20",   4'b0000, 8'h0A, 8'h14, 8'h1E, 0,0,0,0);
      add_vec("add_7f_1",    4'b0000, 8'h7F, 8'h01, 8'h80, 0,1,0,1);
      add_vec("add_ff_1",    4'b0000, 8'hFF, 8'h01, 8'h00, 1,0,1,0);
      add_vec("sub_20_10",   4'b1000, 8'h14, 8'h0A, 8'h0A, 0,0,1,0);
      add_vec("sub_80_1",    4'b1000, 8'h80, 8'h01, 8'h7F, 0,0,1,1);
      add_vec("sub_1_2",     4'b1000, 8'h01, 8'h02, 8'hFF, 0,1,0,0);
      add_vec("sub_eq",      4'b1000, 8'h55, 8'h55, 8'h00, 1,0,1,0);
      add_vec("and",         4'b0111, 8'hCC, 8'hAA, 8'h88, 0,1,0,0);
      add_vec("or",          4'b0110, 8'hCC, 8'hAA, 8'hEE, 0,1,0,0);
      add_vec("xor",         4'b0100, 8'hCC, 8'hAA, 8'h66, 0,0,0,0);
      add_vec("sll_1_2",     4'b0001, 8'h01, 8'h02, 8'h04, 0,0,0,0);
      add_vec("srl_8_2",     4'b0101, 8'h08, 8'h02, 8'h02, 0,0,0,0);
      add_vec("sra_80_2",    4'b1101, 8'h80, 8'h02, 8'hE0, 0,1,0,0);
      add_vec("sll_upper_b", 4'b0001, 8'h01, 8'h0A, 8'h04, 0,0,0,0);
      add_vec("sra_shamt0",  4'b1101, 8'h40, 8'hF8, 8'h40, 0,0,0,0);
      add_vec("sra_81_7",    4'b1101, 8'h81, 8'h07, 8'hFF, 0,1,0,0);
      add_vec("srl_81_7",    4'b0101, 8'h81, 8'h07, 8'h01, 0,0,0,0);
      add_vec("slt_ff_1",    4'b0010, 8'hFF, 8'h01, 8'h01, 0,0,0,0);
      add_vec("sltu_ff_1",   4'b0011, 8'hFF, 8'h01, 8'h00, 1,0,0,0);
      add_vec("slt_1_ff",    4'b0010, 8'h01, 8'hFF, 8'h00, 1,0,0,0);
      add_vec("sltu_1_ff",   4'b0011, 8'h01, 8'hFF, 8'h01, 0,0,0,0);
      add_vec("unk_1010",    4'b1010, 8'h05, 8'h03, 8'h00, 1,0,0,0);
      add_vec("unk_1111",    4'b1111, 8'hFF, 8'hFF, 8'h00, 1,0,0,0);
`ifdef ULA_MUL_EN
      add_vec("mul_13_11",   4'b1001, 8'h0D, 8'h0B, 8'h8F, 0,1,0,0);
`else
      add_vec("op_1001",     4'b1001, 8'h0D, 8'h0B, 8'h00, 1,0,0,0);
`endif

      // reset state while rst_n is low
      #12;
      chk("rst_out", 32'(out), 32'h00);
      chk("rst_flags", 32'(flags()), 32'b1000);
      chk("rst_valid", 32'(out_valid), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back vectors, one per cycle
      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid   = 1'b1;
         dataA      = vecs[i].a;
         dataB      = vecs[i].b;
         ALUControl = vecs[i].op;
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_out"}, 32'(out), 32'(vecs[i].res));
         chk({vecs[i].name, "_zncv"}, 32'(flags()),
             32'({vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v}));
         chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      end

      // known state: ADD 0x7F+1 -> 0x80 N=1 V=1
      @(negedge clk);
      dataA = 8'h7F; dataB = 8'h01; ALUControl = 4'b0000;
      @(posedge clk); #1;
      chk("pre_hold_out", 32'(out), 32'h80);

      // in_valid low: result held, out_valid drops
      @(negedge clk);
      in_valid = 1'b0;
      dataA = 8'h00; dataB = 8'h00; ALUControl = 4'b0111;
      repeat (2) begin
         @(posedge clk); #1;
         chk("hold_out", 32'(out), 32'h80);
         chk("hold_flags", 32'(flags()), 32'b0101);
         chk("hold_valid", 32'(out_valid), 32'd0);
      end

      // latency: new operands do not show before the edge
      @(negedge clk);
      in_valid = 1'b1; dataA = 8'h03; dataB = 8'h04; ALUControl = 4'b0000;
      #2;
      chk("lat_before_edge", 32'(out), 32'h80);
      @(posedge clk); #1;
      chk("lat_after_edge", 32'(out), 32'h07);
      chk("lat_valid", 32'(out_valid), 32'd1);

      // asynchronous reset mid-stream, between edges
      @(negedge clk);
      dataA = 8'h10; dataB = 8'h20;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out", 32'(out), 32'h00);
      chk("arst_flags", 32'(flags()), 32'b1000);
      chk("arst_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("arst_discard_out", 32'(out), 32'h00);
      chk("arst_discard_valid", 32'(out_valid), 32'd0);

      // release reset; first valid result one edge later
      @(negedge clk);
      rst_n = 1'b1;
      dataA = 8'h21; dataB = 8'h01; ALUControl = 4'b1000;
      @(posedge clk); #1;
      chk("post_rst_out", 32'(out), 32'h20);
      chk("post_rst_flags", 32'(flags()), 32'b0010);
      chk("post_rst_valid", 32'(out_valid), 32'd1);

      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/ula.md
Name: ula

Overview:
- Parameterised integer ALU for the RV64 datapath; N-bit operands, 4-bit RISC-V-style operation code, registered result plus Z/N/C/V flags.
- Sits between the register-file read stage and writeback.
- One pipeline register: result and flags appear one clock after operands are sampled.

Parameters:
- N, 8, operand/result width in bits (≥2; the core instantiates 64).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid this cycle
- dataA  in  N  operand A
- dataB  in  N  operand B; low log2(N) bits = shift amount for shifts
- ALUControl  in  4  operation select
- out_valid  out  1  out/flags hold a new result
- out  out  N  registered result
- Overflow  out  1  signed overflow (ADD/SUB only)
- Carry  out  1  carry-out / no-borrow (ADD/SUB only)
- Negative  out  1  out[N-1]
- Zero  out  1  out == 0

Behaviour:
- Opcodes:
  - 0000 ADD: A+B
  - 0001 SLL: A << shamt
  - 0010 SLT: signed A<B ? 1 : 0
  - 0011 SLTU: unsigned compare
  - 0100 XOR
  - 0101 SRL: logical right shift
  - 0110 OR
  - 0111 AND
  - 1000 SUB: A-B
  - 1101 SRA: arithmetic right shift, sign-filled
- Any other code: result 0, Carry=Overflow=0, Zero=1.
- shamt = dataB[$clog2(N)-1:0]; upper bits of B ignored; shamt 0 passes A unchanged.
- Arithmetic is modulo 2^N.
- ADD flags:
  - Carry = bit N of the (N+1)-bit sum.
  - Overflow = A and B same sign and result sign differs.
- SUB flags (computed as A + ~B + 1):
  - Carry = 1 when no borrow (A ≥ B unsigned).
  - Overflow = A and B signs differ and result sign differs from A.
- All non-ADD/SUB ops: Carry=0, Overflow=0.
- Negative and Zero are derived from the final result for every op. SLT/SLTU results are 0 or 1 zero-extended.
- Timing:
  - On a rising clk with in_valid=1: out and flags register the computed values, out_valid←1.
  - With in_valid=0: out_valid←0; out and flags hold their previous values.
  - Latency is exactly 1 cycle; throughput is one op per cycle; no backpressure.
- Reset: while rst_n=0, asynchronously out=0, Overflow=Carry=Negative=0, Zero=1, out_valid=0. An operation in flight when reset asserts is discarded. The first valid result appears one edge after rst_n deasserts with in_valid=1.
- The combinational result path has no latches; all case branches have defaults.

Optional Feature:
- Macro ULA_MUL_EN.
- Defined: opcode 1001 = MUL, out = low N bits of A*B (unsigned product; low half is sign-agnostic). Carry=Overflow=0. Same 1-cycle latency.
- Undefined: 1001 is treated as an unknown code (result 0, Zero=1).

Test Plan:
- ADD 10+20 -> out=30 (0x1E), Z=0 N=0 C=0 V=0; 127+1 -> out=0x80, N=1 C=0 V=1; 0xFF+0x01 -> out=0x00, Z=1 C=1 V=0.
- SUB 20-10 -> out=10, C=1 V=0; 0x80-1 -> out=0x7F, N=0 C=1 V=1; 1-2 -> out=0xFF, N=1 C=0 V=0.
- Logic with A=0xCC, B=0xAA: AND -> 0x88, N=1; OR -> 0xEE; XOR -> 0x66; C=V=0 in all cases.
- Shifts:
  - SLL 0x01 by B=2 -> 0x04.
  - SRL 0x08 by 2 -> 0x02.
  - SRA 0x80 by 2 -> 0xE0, N=1.
  - SLL 0x01 by B=0x0A (shamt 2) -> 0x04.
- Compares: SLT 0xFF<0x01 -> 1; SLTU 0xFF<0x01 -> 0, Z=1; SLT 0x01<0xFF -> 0; SLTU 0x01<0xFF -> 1.
- Timing/reset:
  - Back-to-back valid ops produce results on consecutive cycles with 1-cycle latency.
  - Deasserting in_valid holds out, and out_valid drops.
  - Asserting rst_n=0 mid-stream clears out=0, Z=1, out_valid=0 immediately, without waiting for a clock edge.
  - Unknown opcode 1010 -> out=0, Z=1.
